// File: rtl/sdrc_wrdata_buf_pkg.sv
// ============================================================================
// Module      : sdrc_define (package)
// Description : Shared SDRAM-controller constants and buffer entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdrc_define;

   localparam int c_APP_DW_DEF = 32;
   localparam int c_APP_BW_DEF = 4;
   localparam int c_DEPTH_DEF  = 16;

   // Entry layout is {last, en_n, data}; data always starts at bit 0.
   localparam int c_DATA_LSB = 0;

   function automatic int entry_en_n_lsb(input int dw);
      return dw;
   endfunction

   function automatic int entry_last_pos(input int dw, input int bw);
      return dw + bw;
   endfunction

   function automatic int entry_width(input int dw, input int bw);
      return dw + bw + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sdrc_sync_fifo.sv
// ============================================================================
// Module      : sdrc_sync_fifo
// Description : Generic single-clock FIFO, AW+1 bit wrapping pointers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdrc_sync_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_push_acc,
   output logic             o_pop_acc,
   output logic [AW:0]      o_count
);

   localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] c_ONE  = (AW+1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [AW:0]      w_count;

   assign w_count    = r_wr_ptr - r_rd_ptr;
   assign o_count    = w_count;
   assign o_full     = (w_count == c_FULL);
   assign o_empty    = (w_count == '0);
   // Full refuses a push even when a pop happens the same cycle: no bypass.
   assign o_push_acc = i_push & ~o_full;
   assign o_pop_acc  = i_pop & ~o_empty;
   assign o_head     = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!reset_n || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (o_push_acc) r_wr_ptr <= r_wr_ptr + c_ONE;
         if (o_pop_acc)  r_rd_ptr <= r_rd_ptr + c_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (o_push_acc) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

`default_nettype wire

// File: rtl/sdrc_wrdata_buf.sv
// ============================================================================
// Module      : sdrc_wrdata_buf
// Description : Write-data staging FIFO with complete-burst accounting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdrc_wrdata_buf
   import sdrc_define::*;
#(
   parameter int APP_DW = c_APP_DW_DEF,
   parameter int APP_BW = c_APP_BW_DEF,
   parameter int DEPTH  = c_DEPTH_DEF,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              wr_push_valid,
   input  logic [APP_DW-1:0] wr_push_data,
   input  logic [APP_BW-1:0] wr_push_en_n,
   input  logic              wr_push_last,
   output logic              wr_push_ready,
   output logic [APP_DW-1:0] app_wr_data,
   output logic [APP_BW-1:0] app_wr_en_n,
   input  logic              app_wr_next,
   input  logic              app_last_wr,
   output logic              burst_avail,
   output logic [AW:0]       burst_cnt,
   output logic [AW:0]       fill_cnt,
   output logic              underflow_err,
   output logic              burst_err
);

   localparam int          c_EW    = entry_width(APP_DW, APP_BW);
   localparam int          c_LAST  = entry_last_pos(APP_DW, APP_BW);
   localparam int          c_EN_LO = entry_en_n_lsb(APP_DW);
   localparam logic [AW:0] c_MAX   = (AW+1)'(DEPTH);
   localparam logic [AW:0] c_ONE   = (AW+1)'(1);

   logic [c_EW-1:0] w_entry_in;
   logic [c_EW-1:0] w_head;
   logic            w_full;
   logic            w_empty;
   logic            w_push_acc;
   logic            w_pop_acc;
   logic            w_head_last;
   logic            w_inc;
   logic [AW:0]     r_burst_cnt;
   logic [AW:0]     w_burst_cnt_nxt;
   logic            r_underflow_err;
   logic            r_burst_err;
   logic            w_burst_err_nxt;

   assign w_entry_in = {wr_push_last, wr_push_en_n, wr_push_data};

   sdrc_sync_fifo #(
      .WIDTH (c_EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_flush    (flush),
      .i_push     (wr_push_valid),
      .i_data     (w_entry_in),
      .i_pop      (app_wr_next),
      .o_head     (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_push_acc (w_push_acc),
      .o_pop_acc  (w_pop_acc),
      .o_count    (fill_cnt)
   );

   // An empty buffer presents a fully masked beat so a stray write is harmless.
   assign app_wr_data   = w_empty ? '0 : w_head[c_DATA_LSB +: APP_DW];
   assign app_wr_en_n   = w_empty ? '1 : w_head[c_EN_LO +: APP_BW];
   assign w_head_last   = w_head[c_LAST];
   assign wr_push_ready = ~w_full;
   assign w_inc         = w_push_acc & wr_push_last;

   always_comb begin
      w_burst_cnt_nxt = r_burst_cnt;
      w_burst_err_nxt = r_burst_err
                      | (app_last_wr & w_pop_acc & ~w_head_last)
                      | (app_last_wr & ~app_wr_next)
                      | (w_pop_acc & w_head_last & ~app_last_wr);
      if (w_inc && !app_last_wr) begin
         if (r_burst_cnt != c_MAX) w_burst_cnt_nxt = r_burst_cnt + c_ONE;
      end else if (app_last_wr && !w_inc) begin
         if (r_burst_cnt == '0) w_burst_err_nxt = 1'b1;
         else                   w_burst_cnt_nxt = r_burst_cnt - c_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         r_burst_cnt     <= '0;
         r_underflow_err <= 1'b0;
         r_burst_err     <= 1'b0;
      end else begin
         r_burst_cnt     <= w_burst_cnt_nxt;
         r_underflow_err <= r_underflow_err | (app_wr_next & w_empty);
         r_burst_err     <= w_burst_err_nxt;
      end
   end

   assign burst_cnt     = r_burst_cnt;
   assign burst_avail   = (r_burst_cnt != '0);
   assign underflow_err = r_underflow_err;
   assign burst_err     = r_burst_err;

endmodule

`default_nettype wire

// File: tb/tb_sdrc_wrdata_buf.sv
// ============================================================================
// Module      : tb_sdrc_wrdata_buf
// Description : Directed plus randomized bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdrc_wrdata_buf;

   localparam int c_DEPTH = 16;

   typedef struct {
      bit        last;
      bit [3:0]  en_n;
      bit [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        wr_push_valid = 1'b0;
   logic [31:0] wr_push_data = '0;
   logic [3:0]  wr_push_en_n = '0;
   logic        wr_push_last = 1'b0;
   logic        wr_push_ready;
   logic [31:0] app_wr_data;
   logic [3:0]  app_wr_en_n;
   logic        app_wr_next = 1'b0;
   logic        app_last_wr = 1'b0;
   logic        burst_avail;
   logic [4:0]  burst_cnt;
   logic [4:0]  fill_cnt;
   logic        underflow_err;
   logic        burst_err;

   beat_t m_q[$];
   int    m_bc = 0;
   bit    m_uf = 0;
   bit    m_be = 0;
   int    n_checks = 0;
   int    n_pass = 0;

   always #5 clk = ~clk;

   sdrc_wrdata_buf dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .flush         (flush),
      .wr_push_valid (wr_push_valid),
      .wr_push_data  (wr_push_data),
      .wr_push_en_n  (wr_push_en_n),
      .wr_push_last  (wr_push_last),
      .wr_push_ready (wr_push_ready),
      .app_wr_data   (app_wr_data),
      .app_wr_en_n   (app_wr_en_n),
      .app_wr_next   (app_wr_next),
      .app_last_wr   (app_last_wr),
      .burst_avail   (burst_avail),
      .burst_cnt     (burst_cnt),
      .fill_cnt      (fill_cnt),
      .underflow_err (underflow_err),
      .burst_err     (burst_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Compare every output against the model's view of the buffer.
   task automatic check_model();
      bit        emp;
      emp = (m_q.size() == 0);
      chk("fill_cnt", 64'(fill_cnt), 64'(m_q.size()));
      chk("burst_cnt", 64'(burst_cnt), 64'(m_bc));
      chk("burst_avail", 64'(burst_avail), 64'(m_bc != 0));
      chk("wr_push_ready", 64'(wr_push_ready), 64'(m_q.size() != c_DEPTH));
      chk("app_wr_data", 64'(app_wr_data), emp ? 64'h0 : 64'(m_q[0].data));
      chk("app_wr_en_n", 64'(app_wr_en_n), emp ? 64'hF : 64'(m_q[0].en_n));
      chk("underflow_err", 64'(underflow_err), 64'(m_uf));
      chk("burst_err", 64'(burst_err), 64'(m_be));
   endtask

   task automatic model_step(input bit v, input bit [31:0] d, input bit [3:0] en,
                             input bit l, input bit nx, input bit lw, input bit fl);
      bit    emp, full, push_ok, pop_ok, hl, inc;
      beat_t b;
      if (fl) begin
         m_q.delete(); m_bc = 0; m_uf = 0; m_be = 0;
         return;
      end
      emp     = (m_q.size() == 0);
      full    = (m_q.size() == c_DEPTH);
      push_ok = v && !full;
      pop_ok  = nx && !emp;
      hl      = !emp && m_q[0].last;
      inc     = push_ok && l;
      if (nx && emp) m_uf = 1;
      if (lw && pop_ok && !hl) m_be = 1;
      if (lw && !nx) m_be = 1;
      if (pop_ok && hl && !lw) m_be = 1;
      if (inc && !lw) begin
         if (m_bc < c_DEPTH) m_bc++;
      end else if (lw && !inc) begin
         if (m_bc == 0) m_be = 1;
         else m_bc--;
      end
      if (pop_ok) void'(m_q.pop_front());
      if (push_ok) begin
         b.last = l; b.en_n = en; b.data = d;
         m_q.push_back(b);
      end
   endtask

   // One clock: drive, advance model, clock, then compare after the edge.
   task automatic cyc(input bit v, input bit [31:0] d, input bit [3:0] en,
                      input bit l, input bit nx, input bit lw, input bit fl);
      wr_push_valid = v; wr_push_data = d; wr_push_en_n = en; wr_push_last = l;
      app_wr_next = nx; app_last_wr = lw; flush = fl;
      model_step(v, d, en, l, nx, lw, fl);
      @(posedge clk);
      #1;
      wr_push_valid = 0; app_wr_next = 0; app_last_wr = 0; flush = 0;
      wr_push_last = 0;
      check_model();
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input bit [31:0] d, input bit l);
      cyc(1, d, 4'h0, l, 0, 0, 0);
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && m_q.size() != 0; k++)
         cyc(0, 0, 0, 0, 1, m_q[0].last, 0);
   endtask

   initial begin
      reset_n = 0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1;
      check_model();
      chk("rst fill_cnt", 64'(fill_cnt), 64'd0);
      chk("rst burst_avail", 64'(burst_avail), 64'd0);
      chk("rst ready", 64'(wr_push_ready), 64'd1);
      chk("rst en_n", 64'(app_wr_en_n), 64'hF);
      chk("rst data", 64'(app_wr_data), 64'd0);

      for (int i = 0; i < 4; i++) push(32'h11111111 * (i + 1), i == 3);
      chk("b4 burst_cnt", 64'(burst_cnt), 64'd1);
      for (int i = 0; i < 4; i++) begin
         chk("b4 head data", 64'(app_wr_data), 64'(32'h11111111 * (i + 1)));
         cyc(0, 0, 0, 0, 1, i == 3, 0);
      end
      chk("b4 burst_cnt end", 64'(burst_cnt), 64'd0);
      chk("b4 fill end", 64'(fill_cnt), 64'd0);
      chk("b4 burst_err", 64'(burst_err), 64'd0);

      for (int i = 0; i < 16; i++) push(32'hA0000000 + i, (i % 8) == 7);
      chk("full ready", 64'(wr_push_ready), 64'd0);
      chk("full burst_cnt", 64'(burst_cnt), 64'd2);
      push(32'hDEADBEEF, 0);
      chk("full 17th ignored", 64'(fill_cnt), 64'd16);
      cyc(1, 32'hCAFEF00D, 4'h0, 0, 1, 0, 0);
      chk("full push+pop", 64'(fill_cnt), 64'd15);
      chk("full new head", 64'(app_wr_data), 64'hA0000001);
      drain();

      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("underflow set", 64'(underflow_err), 64'd1);
      idle();
      chk("underflow sticky", 64'(underflow_err), 64'd1);
      push(32'h55555555, 0);
      push(32'h66666666, 1);
      drain();
      chk("post-uf burst_err", 64'(burst_err), 64'd0);

      push(32'h77777777, 0);
      push(32'h88888888, 1);
      cyc(0, 0, 0, 0, 1, 1, 0);
      chk("mismatch burst_err", 64'(burst_err), 64'd1);

      push(32'h99999999, 0);
      push(32'hAAAAAAAA, 0);
      chk("pre-flush fill", 64'(fill_cnt), 64'd3);
      cyc(1, 32'hBBBBBBBB, 4'h0, 1, 0, 0, 1);
      chk("flush fill", 64'(fill_cnt), 64'd0);
      chk("flush burst_cnt", 64'(burst_cnt), 64'd0);
      chk("flush burst_err", 64'(burst_err), 64'd0);
      chk("flush underflow", 64'(underflow_err), 64'd0);
      chk("flush ready", 64'(wr_push_ready), 64'd1);

      for (int i = 0; i < 3000; i++) begin
         bit v, l, nx, lw, fl;
         v  = ($urandom_range(0, 99) < 60);
         l  = ($urandom_range(0, 3) == 0);
         nx = ($urandom_range(0, 1) == 1);
         lw = nx && m_q.size() != 0 && m_q[0].last;
         if ($urandom_range(0, 31) == 0) lw = ~lw;
         fl = ($urandom_range(0, 63) == 0);
         cyc(v, $urandom, 4'($urandom), l, nx, lw, fl);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
